// File: rtl/object_renderer_pkg.sv
// Shared definitions for the object renderer: screen-size defaults, FSM state
// encoding, sprite size lookup and sprite colour expansion.
package object_renderer_pkg;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;
    localparam int CODE_W       = 5;   // sprite code width per slot
    localparam int POS_W        = 17;  // {x[8:0], y[7:0]} per slot

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SETUP = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Box width for code[1:0]: 8, 16, 32, 48
    function automatic logic [5:0] box_w(input logic [1:0] sz);
        logic [5:0] w;
        case (sz)
            2'd0:    w = 6'd8;
            2'd1:    w = 6'd16;
            2'd2:    w = 6'd32;
            2'd3:    w = 6'd48;
            default: w = 6'd8;
        endcase
        return w;
    endfunction

    // Box height for code[1:0]: 8, 16, 8, 16
    function automatic logic [4:0] box_h(input logic [1:0] sz);
        logic [4:0] h;
        case (sz)
            2'd0:    h = 5'd8;
            2'd1:    h = 5'd16;
            2'd2:    h = 5'd8;
            2'd3:    h = 5'd16;
            default: h = 5'd8;
        endcase
        return h;
    endfunction

    // code[4:2] = {R,G,B}; each bit becomes a full or empty 4-bit channel
    function automatic logic [11:0] expand_colour(input logic [2:0] rgb);
        return {{4{rgb[2]}}, {4{rgb[1]}}, {4{rgb[0]}}};
    endfunction

endpackage

// File: rtl/object_renderer_sprite_walker.sv
// sprite_walker: row-major column/row counter for one box, plus clipping.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   load_i             latch origin/size and point at the first pixel
//   step_i             advance to the next pixel of the box
//   x0_i, y0_i         box origin;  w_i, h_i  box size
//   nxt_x_o, nxt_y_o   coordinates of the pixel that becomes current next cycle
//   nxt_vis_o          that pixel lies inside the screen
//   last_o             the current pixel is the last pixel of the box
module sprite_walker
    import object_renderer_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic       step_i,
    input  logic [8:0] x0_i,
    input  logic [7:0] y0_i,
    input  logic [5:0] w_i,
    input  logic [4:0] h_i,
    output logic [8:0] nxt_x_o,
    output logic [7:0] nxt_y_o,
    output logic       nxt_vis_o,
    output logic       last_o
);

    logic [8:0] x0_q, x0_d;
    logic [7:0] y0_q, y0_d;
    logic [5:0] w_q, w_d, col_q, col_d;
    logic [4:0] h_q, h_d, row_q, row_d;
    logic [9:0] sum_x_s, sum_y_s;
    logic       col_end_s;

    assign col_end_s = (col_q == (w_q - 6'd1));
    assign last_o    = col_end_s && (row_q == (h_q - 5'd1));

    // Next counter/origin values: load restarts the box, step walks row-major
    always_comb begin
        x0_d  = x0_q;
        y0_d  = y0_q;
        w_d   = w_q;
        h_d   = h_q;
        col_d = col_q;
        row_d = row_q;
        if (load_i) begin
            x0_d  = x0_i;
            y0_d  = y0_i;
            w_d   = w_i;
            h_d   = h_i;
            col_d = 6'd0;
            row_d = 5'd0;
        end else if (step_i) begin
            if (col_end_s) begin
                col_d = 6'd0;
                row_d = row_q + 5'd1;
            end else begin
                col_d = col_q + 6'd1;
            end
        end else begin
            col_d = col_q;
        end
    end

    // Coordinates are formed at 10 bits so a box hanging off the edge never wraps
    assign sum_x_s   = {1'b0, x0_d} + {4'd0, col_d};
    assign sum_y_s   = {2'd0, y0_d} + {5'd0, row_d};
    assign nxt_x_o   = sum_x_s[8:0];
    assign nxt_y_o   = sum_y_s[7:0];
    assign nxt_vis_o = (sum_x_s < 10'(SCREEN_W)) && (sum_y_s < 10'(SCREEN_H));

    // Counter and box registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x0_q  <= 9'd0;
            y0_q  <= 8'd0;
            w_q   <= 6'd0;
            h_q   <= 5'd0;
            col_q <= 6'd0;
            row_q <= 5'd0;
        end else begin
            x0_q  <= x0_d;
            y0_q  <= y0_d;
            w_q   <= w_d;
            h_q   <= h_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/object_renderer.sv
// object_renderer: draws up to NSLOTS solid boxes (optionally over a cleared
// background) into a VGA adapter, one pixel write per cycle.
// Ports:
//   CLOCK_50, reset        clock, synchronous active-high reset
//   start                  request one frame (honoured only when idle)
//   background             clear colour (4:4:4 RGB)
//   inputs                 NSLOTS x 5-bit sprite codes
//   pos                    NSLOTS x {x[8:0], y[7:0]} box origins
//   x, y, colour, plot     registered pixel write
//   busy, done             frame in progress / one-cycle completion pulse
module object_renderer
    import object_renderer_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int NSLOTS   = 6,
    parameter int CLEAR_EN = 1
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       start,
    input  logic [11:0]                background,
    input  logic [CODE_W*NSLOTS-1:0]   inputs,
    input  logic [POS_W*NSLOTS-1:0]    pos,
    output logic [8:0]                 x,
    output logic [7:0]                 y,
    output logic [11:0]                colour,
    output logic                       plot,
    output logic                       busy,
    output logic                       done
);

    localparam int SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(NSLOTS - 1);

    state_e                     state_q;
    logic [SW-1:0]              slot_q;
    logic [CODE_W*NSLOTS-1:0]   code_q;
    logic [POS_W*NSLOTS-1:0]    pos_q;
    logic [11:0]                bg_q;
    logic [8:0]                 cx_q, cx_nxt_s, x_q;
    logic [7:0]                 cy_q, cy_nxt_s, y_q;
    logic [11:0]                colour_q;
    logic                       plot_q, busy_q, done_q;

    logic [4:0]                 cur_code_s;
    logic [8:0]                 cur_x0_s, wk_x_s;
    logic [7:0]                 cur_y0_s, wk_y_s;
    logic                       wk_load_s, wk_step_s, wk_vis_s, wk_last_s;
    logic                       clr_last_s, slot_last_s;

    // Current slot fields come from the snapshot, never from the live bus
    assign cur_code_s  = code_q[int'(slot_q)*CODE_W +: CODE_W];
    assign cur_x0_s    = pos_q[int'(slot_q)*POS_W + 8 +: 9];
    assign cur_y0_s    = pos_q[int'(slot_q)*POS_W +: 8];
    assign slot_last_s = (slot_q == LAST_SLOT);
    assign clr_last_s  = (cx_q == 9'(SCREEN_W - 1)) && (cy_q == 8'(SCREEN_H - 1));

    assign wk_load_s = (state_q == S_SETUP) && (cur_code_s != 5'd0);
    assign wk_step_s = (state_q == S_DRAW) && !wk_last_s;

    sprite_walker #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_walker (
        .clk_i     (CLOCK_50),
        .reset_i   (reset),
        .load_i    (wk_load_s),
        .step_i    (wk_step_s),
        .x0_i      (cur_x0_s),
        .y0_i      (cur_y0_s),
        .w_i       (box_w(cur_code_s[1:0])),
        .h_i       (box_h(cur_code_s[1:0])),
        .nxt_x_o   (wk_x_s),
        .nxt_y_o   (wk_y_s),
        .nxt_vis_o (wk_vis_s),
        .last_o    (wk_last_s)
    );

    // Next raster position of the background clear
    always_comb begin
        cx_nxt_s = cx_q + 9'd1;
        cy_nxt_s = cy_q;
        if (cx_q == 9'(SCREEN_W - 1)) begin
            cx_nxt_s = 9'd0;
            cy_nxt_s = cy_q + 8'd1;
        end else begin
            cy_nxt_s = cy_q;
        end
    end

    // Frame FSM; pixel outputs are registered together with the state they belong to
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= S_IDLE;
            slot_q   <= '0;
            code_q   <= '0;
            pos_q    <= '0;
            bg_q     <= 12'd0;
            cx_q     <= 9'd0;
            cy_q     <= 8'd0;
            x_q      <= 9'd0;
            y_q      <= 8'd0;
            colour_q <= 12'd0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    plot_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        code_q <= inputs;
                        pos_q  <= pos;
                        bg_q   <= background;
                        slot_q <= '0;
                        busy_q <= 1'b1;
                        if (CLEAR_EN != 0) begin
                            state_q  <= S_CLEAR;
                            cx_q     <= 9'd0;
                            cy_q     <= 8'd0;
                            x_q      <= 9'd0;
                            y_q      <= 8'd0;
                            colour_q <= background;
                            plot_q   <= 1'b1;
                        end else begin
                            state_q <= S_SETUP;
                        end
                    end
                end
                S_CLEAR: begin
                    if (clr_last_s) begin
                        state_q <= S_SETUP;
                        plot_q  <= 1'b0;
                    end else begin
                        cx_q     <= cx_nxt_s;
                        cy_q     <= cy_nxt_s;
                        x_q      <= cx_nxt_s;
                        y_q      <= cy_nxt_s;
                        colour_q <= bg_q;
                        plot_q   <= 1'b1;
                    end
                end
                S_SETUP: begin
                    plot_q <= 1'b0;
                    if (cur_code_s != 5'd0) begin
                        // Walker is loaded this same edge; its first pixel goes out now
                        state_q  <= S_DRAW;
                        x_q      <= wk_x_s;
                        y_q      <= wk_y_s;
                        colour_q <= expand_colour(cur_code_s[4:2]);
                        plot_q   <= wk_vis_s;
                    end else if (slot_last_s) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        slot_q <= slot_q + SW'(1);
                    end
                end
                S_DRAW: begin
                    if (wk_last_s) begin
                        plot_q <= 1'b0;
                        if (slot_last_s) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SETUP;
                            slot_q  <= slot_q + SW'(1);
                        end
                    end else begin
                        x_q    <= wk_x_s;
                        y_q    <= wk_y_s;
                        plot_q <= wk_vis_s;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/object_renderer.md
OBJECT_RENDERER -- requirements
Module: object_renderer

Interface
REQ-001 Parameter SCREEN_W, default 320, meaning visible width in pixels.
REQ-002 Parameter SCREEN_H, default 240, meaning visible height in pixels.
REQ-003 Parameter NSLOTS, default 6, meaning number of object slots in the descriptor bus.
REQ-004 Parameter CLEAR_EN, default 1, meaning fill the screen with background before drawing slots.
REQ-005 Port CLOCK_50 in 1: sole clock, all logic on its rising edge.
REQ-006 Port reset in 1: synchronous, active-high reset.
REQ-007 Port start in 1: one-cycle request to render one frame.
REQ-008 Port background in 12: clear colour, 4:4:4 RGB.
REQ-009 Port inputs in 5*NSLOTS: slot i sprite code at [5i+4:5i].
REQ-010 Port pos in 17*NSLOTS: slot i position at [17i+16:17i]; x = [17i+16:17i+8] (9 bits), y = [17i+7:17i] (8 bits).
REQ-011 Port x out 9, y out 8, colour out 12: pixel write to the VGA adapter.
REQ-012 Port plot out 1: pixel write strobe, qualifies x/y/colour in the same cycle.
REQ-013 Port busy out 1: high from the cycle after an accepted start until done.
REQ-014 Port done out 1: one-cycle pulse when a frame is complete.

Function
REQ-015 Sprite code 0 SHALL mean an empty slot; nothing drawn.
REQ-016 code[1:0] SHALL select the box size: 0 = 8x8, 1 = 16x16, 2 = 32x8, 3 = 48x16 (width x height).
REQ-017 code[4:2] SHALL select the colour: each bit R, G, B expands to 4'hF or 4'h0; a value of 0 draws black.
REQ-018 A start seen in IDLE SHALL snapshot inputs, pos and background into internal registers; later bus changes SHALL NOT affect the frame in progress.
REQ-019 A start while busy SHALL be ignored.
REQ-020 States: IDLE, CLEAR, SETUP, DRAW, DONE.
REQ-021 IDLE -> CLEAR on start when CLEAR_EN=1, otherwise IDLE -> SETUP with slot 0.
REQ-022 CLEAR SHALL emit one plot per cycle in raster order, (0,0) to (SCREEN_W-1,SCREEN_H-1), colour = background, then go to SETUP slot 0.
REQ-023 SETUP SHALL take exactly one cycle with plot=0.
REQ-024 From SETUP, a non-empty slot SHALL go to DRAW; an empty slot SHALL go to the next slot's SETUP.
REQ-025 After the last slot, SETUP SHALL go to DONE.
REQ-026 DRAW SHALL walk the box row-major from (x0,y0), one pixel per cycle, for exactly w*h cycles, then go to the next SETUP (or DONE after slot NSLOTS-1).
REQ-027 Pixel coordinates SHALL be computed at 10 bits with no wrap.
REQ-028 A pixel with x >= SCREEN_W or y >= SCREEN_H SHALL hold plot=0 for its cycle; the cycle count is unchanged.
REQ-029 Slots SHALL be drawn in ascending index, so a higher slot overwrites a lower one where they overlap.
REQ-030 DONE SHALL assert done for one cycle, drop busy in the same cycle, then return to IDLE.
REQ-031 A start in the DONE cycle SHALL be ignored.
REQ-032 The first CLEAR plot SHALL appear the cycle after start is accepted; total frame length is deterministic.
REQ-033 Frame length SHALL be CLEAR_EN*W*H + NSLOTS + sum(w*h of non-empty slots) + 1 cycles.
REQ-034 x, y and colour SHALL be registered outputs; their values are don't-care when plot=0.

Reset
REQ-035 Reset SHALL force state IDLE, clear all counters and snapshots, and drive plot=0, busy=0, done=0, x=0, y=0, colour=0 on the next edge.
REQ-036 Reset mid-frame SHALL abort the frame with no done pulse.
REQ-037 Reset SHALL take priority over a simultaneous start.

Structure
REQ-038 A shared package SHALL hold SCREEN_W/SCREEN_H defaults, the state encoding, the size lookup (code[1:0] -> w,h) and the colour expansion function.
REQ-039 One sub-module, sprite_walker, SHALL perform the per-box row/column counting and clipping; the FSM and snapshot registers stay in object_renderer.

Verification
REQ-040 Test: CLEAR_EN=0, all slots 0, start -> 6 SETUP cycles, then done on cycle 7 after start, and plot never asserted.
REQ-041 Test: CLEAR_EN=0, slot 0 = 5'b00100 at (64,100) -> 64 plots covering x 64..71, y 100..107, colour 12'h00F, done 1+64+6 cycles after start.
REQ-042 Test: CLEAR_EN=0, slot 2 = 5'b11111 at (300,230) -> 768 DRAW cycles and only 20x10=200 plots, colour 12'hFFF, no coordinate >= 320/240.
REQ-043 Test: CLEAR_EN=1, background=12'h123 -> exactly 76800 plots of 12'h123 in raster order.
REQ-044 Test: change pos mid-frame and pulse start during DRAW -> output matches the original snapshot and the extra start is ignored.
REQ-045 Test: assert reset during DRAW -> plot=0 and busy=0 on the next edge, no done pulse, and a following start renders a full frame.
